// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA raster constants, counter width and stage-0 bundle type.
// Default 640x480@60 porch/sync values; imported by generator and pixel stage.
package vga_timing_gen_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic fin;
    logic vs_n;
    logic hs_n;
    logic active;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{
    fin:    1'b0,
    vs_n:   1'b1,
    hs_n:   1'b1,
    active: 1'b0
  };

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// vga_delay_line: WIDTH x DEPTH shift register, sync active-low reset to RST_VAL.
// Ports: i_clk, i_rst_n, i_d[WIDTH] in; o_q[WIDTH] = i_d delayed DEPTH cycles.
module vga_delay_line #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, stage-0 decode, frame count, aligned syncs.
// In: I_25MHZ_CLK, I_RESET(n). Out: O_X/O_Y raw; syncs/strobes lag PIPE_LAT.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_LAT = 2,
  parameter int FRAME_W  = 16
) (
  input  logic               I_25MHZ_CLK,
  input  logic               I_RESET,
  output logic [CNT_W-1:0]   O_X,
  output logic [CNT_W-1:0]   O_Y,
  output logic               O_HSYNC,
  output logic               O_VSYNC,
  output logic               display_data,
  output logic               draw_finish,
  output logic [FRAME_W-1:0] O_FRAME
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LASTV = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]   r_h;
  logic [CNT_W-1:0]   r_v;
  logic [FRAME_W-1:0] r_frame;
  stage_t             w_s0;
  stage_t             w_dly;

  always_ff @(posedge I_25MHZ_CLK) begin
    if (!I_RESET) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  always_comb begin
    w_s0        = STAGE_IDLE;
    w_s0.active = (r_h < H_VIS) && (r_v < V_VIS);
    w_s0.hs_n   = !((r_h >= HS_BEG) && (r_h < HS_END));
    w_s0.vs_n   = !((r_v >= VS_BEG) && (r_v < VS_END));
    // first cycle past the last visible pixel of the frame
    w_s0.fin    = (r_h == H_VIS) && (r_v == V_LASTV);
  end

  always_ff @(posedge I_25MHZ_CLK) begin
    if (!I_RESET) begin
      r_frame <= '0;
    end else if (w_s0.fin) begin
      r_frame <= r_frame + 1'b1;
    end
  end

  vga_delay_line #(
    .WIDTH   ($bits(stage_t)),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (STAGE_IDLE)
  ) u_dly (
    .i_clk   (I_25MHZ_CLK),
    .i_rst_n (I_RESET),
    .i_d     (w_s0),
    .o_q     (w_dly)
  );

  assign O_X          = r_h;
  assign O_Y          = r_v;
  assign O_HSYNC      = w_dly.hs_n;
  assign O_VSYNC      = w_dly.vs_n;
  assign display_data = w_dly.active;
  assign draw_finish  = w_dly.fin;
  assign O_FRAME      = r_frame;

endmodule
